// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width, default bit period.
// BAUD_CNT_DEFAULT is the clocks-per-bit default used by both uart_tx and uart_rx.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int DATA_BITS        = 8;
    localparam int BAUD_CNT_DEFAULT = 434;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// rx line conditioning: 2-flop synchroniser, one history flop, falling-edge strobe and sample value.
// UART_RX_MAJORITY_EN: sample = 2-of-3 vote over rx_s at (t-1, t, t+1), using the sync flop as the t+1 tap.
module uart_rx_filter
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall,
    output logic o_sample
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign o_rx_s = r_sync2;
    assign o_fall = r_hist & ~r_sync2;

`ifdef UART_RX_MAJORITY_EN
    // r_sync1 already holds next cycle's rx_s, so the vote is centred without extra latency
    assign o_sample = maj3(r_sync1, r_sync2, r_hist);
`else
    assign o_sample = r_sync2;
`endif

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, one-entry holding register, framing/overrun pulses.
// Optional glitch-rejecting sample vote enabled by UART_RX_MAJORITY_EN (see uart_rx_filter).
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_CNT = BAUD_CNT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW   = $clog2(BAUD_CNT);
    localparam int HALF = BAUD_CNT / 2;

    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(BAUD_CNT - 1);
    localparam logic [2:0]    IDX_LAST      = 3'(DATA_BITS - 1);

    logic w_rx_s;
    logic w_fall;
    logic w_sample;

    rx_state_t      r_state;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_idx;
    logic [7:0]     r_shift;

    uart_rx_filter u_filter (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_rx     (rx),
        .o_rx_s   (w_rx_s),
        .o_fall   (w_fall),
        .o_sample (w_sample)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready)
                valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_fall && !w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == CNT_HALF_LAST) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        r_state <= w_sample ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_sample, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == IDX_LAST)
                            r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (r_cnt == CNT_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (!w_sample) begin
                            frame_err <= 1'b1;
                        end else if (!valid || ready) begin
                            // a same-cycle accept frees the slot, so the new byte replaces it
                            data  <= r_shift;
                            valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed frames checked against a queue/count model of the receiver.
module tb_uart_rx;

    localparam int B = 10;
    localparam int H = B / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(.BAUD_CNT(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observed behaviour
    logic [7:0] acc_q[$];
    int         vrise_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;

    // Reference model state
    logic [7:0] exp_q[$];
    int         exp_fe = 0;
    int         exp_ov = 0;
    int         t0 = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (valid && ready) acc_q.push_back(data);
            if (valid && !pv) vrise_q.push_back(cyc);
            fe_cnt += int'(frame_err);
            ov_cnt += int'(overrun);
            if (pv && !pr) begin
                chk("hold_valid", 32'(valid), 32'd1);
                chk("hold_data", 32'(data), 32'(pd));
            end
        end
        pv = valid;
        pr = ready;
        pd = data;
    end

    // Drives one 10-bit frame, one bit every B clocks; optional 1-cycle inversion at offset glitch.
    task automatic send(input logic [7:0] b, input logic stop, input int glitch, input int cut);
        logic [9:0] fr;
        logic       v;
        fr = {stop, b, 1'b0};
        for (int n = 0; n < 10 * B && n < cut; n++) begin
            @(posedge clk); #1;
            if (n == 0) t0 = cyc;
            v = fr[n / B];
            if (n == glitch) v = ~v;
            rx = v;
        end
    endtask

    task automatic line(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx = lvl;
        end
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            if (acc_q.size() == 0) begin
                chk({tag, "_count"}, 32'(acc_q.size()), 32'(exp_q.size()));
                exp_q.delete();
            end else begin
                chk(tag, 32'(acc_q.pop_front()), 32'(exp_q.pop_front()));
            end
        end
        chk({tag, "_extra"}, 32'(acc_q.size()), 32'd0);
        acc_q.delete();
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        logic [7:0] g_exp;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b1;
        line(1'b1, 20);

        // Single frame, latency: 2 sync cycles to detection, then B/2 + 9B + 1
        vrise_q.delete();
        send(8'hB9, 1'b1, -1, 1000);
        exp_q.push_back(8'hB9);
        line(1'b1, 20);
        chk("lat_b9", 32'(vrise_q.size() > 0 ? vrise_q[0] - t0 : -1), 32'(2 + H + 9 * B + 1));
        drain("t1_data");
        chk("t1_ferr", 32'(fe_cnt), 32'(exp_fe));
        chk("t1_ovr", 32'(ov_cnt), 32'(exp_ov));

        // Overrun: second byte dropped while the first waits
        ready = 1'b0;
        send(8'h3C, 1'b1, -1, 1000);
        send(8'hA5, 1'b1, -1, 1000);
        exp_ov++;
        line(1'b1, 20);
        chk("ovr_valid", 32'(valid), 32'd1);
        chk("ovr_data", 32'(data), 32'h3C);
        chk("ovr_count", 32'(ov_cnt), 32'(exp_ov));
        ready = 1'b1;
        @(posedge clk); #1;
        chk("ovr_release", 32'(valid), 32'd0);
        exp_q.push_back(8'h3C);
        drain("t2_data");

        // Framing error, then a long break, then a good frame
        send(8'h55, 1'b0, -1, 1000);
        exp_fe++;
        line(1'b0, 30 * B);
        line(1'b1, 30);
        chk("fe_count", 32'(fe_cnt), 32'(exp_fe));
        chk("fe_valid", 32'(valid), 32'd0);
        send(8'h81, 1'b1, -1, 1000);
        exp_q.push_back(8'h81);
        line(1'b1, 20);
        drain("t3_data");

        // 3-cycle low glitch on idle line
        line(1'b0, 3);
        line(1'b1, 30);
        chk("glitch_valid", 32'(valid), 32'd0);
        chk("glitch_fe", 32'(fe_cnt), 32'(exp_fe));
        drain("t4_data");

        // Reset in the middle of data bit 4
        send(8'hFF, 1'b1, -1, 5 * B + 3);
        rst = 1'b0;
        #1;
        chk("mid_rst_data", 32'(data), 32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        line(1'b1, 3);
        rst = 1'b1;
        line(1'b1, 20);
        send(8'h12, 1'b1, -1, 1000);
        exp_q.push_back(8'h12);
        line(1'b1, 20);
        drain("t5_data");

        // One-cycle high glitch at the data bit 2 sample point
        send(8'h00, 1'b1, H + 3 * B, 1000);
`ifdef UART_RX_MAJORITY_EN
        g_exp = 8'h00;
`else
        g_exp = 8'h04;
`endif
        exp_q.push_back(g_exp);
        line(1'b1, 20);
        drain("t6_glitch");

        // Random frames with occasional bad stop bits and random gaps
        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send(rb, rs, -1, 1000);
            if (rs) exp_q.push_back(rb);
            else    exp_fe++;
            line(1'b1, $urandom_range(0, 12) + (rs ? 0 : 2));
        end
        line(1'b1, 30);
        drain("rand_data");

        chk("total_ferr", 32'(fe_cnt), 32'(exp_fe));
        chk("total_ovr", 32'(ov_cnt), 32'(exp_ov));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart to the team's uart_tx. It shares the BAUD_CNT meaning and the data/valid/ready byte interface style.
- Synchronises the asynchronous rx line and detects the start bit. Samples each bit at mid-period and presents the received byte on a valid/ready handshake with a one-entry holding register.
- Flags framing and overrun errors.

Parameters:
- BAUD_CNT, 434, clock cycles per bit period (50 MHz / 115200). Must be >= 4. Half period = BAUD_CNT/2, truncated.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- rx  in  1  serial line, idle high, asynchronous to clk
- data  out  8  received byte, LSB first on the line; stable while valid=1
- valid  out  1  byte available in holding register
- ready  in  1  consumer accepts the byte when valid&&ready on a clk edge
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- overrun  out  1  one-cycle pulse: a completed byte was dropped because the holding register was full

Behaviour:
- Reset (rst=0, async) sets: state=IDLE; data=8'h00; valid=0; frame_err=0; overrun=0; counters=0; synchroniser flops=1.
- Synchroniser: rx passes through 2 flops to give rx_s, plus one history flop rx_d. Detection cycle is defined as the cycle where rx_d=1 and rx_s=0.
- IDLE: on the detection cycle, go to START and clear the baud counter.
- START:
  - The counter runs to BAUD_CNT/2-1, then rx_s is sampled.
  - Sample 0: go to DATA with bit index 0.
  - Sample 1: false start, back to IDLE, no flags.
- DATA:
  - Every BAUD_CNT cycles, sample rx_s into shift bit[idx], LSB first.
  - After bit 7, go to STOP.
- STOP: after BAUD_CNT cycles, sample rx_s.
  - Sample 1: byte complete; attempt load (rules below).
  - Sample 0: pulse frame_err for 1 cycle, discard the byte.
  - In both cases return to IDLE.
- A line held low (break) never retriggers, because IDLE requires a 1->0 edge.
- Sample timing relative to the detection cycle (counted as cycle 0):
  - start sample at cycle BAUD_CNT/2;
  - data bit k at BAUD_CNT/2 + (k+1)*BAUD_CNT;
  - stop sample at BAUD_CNT/2 + 9*BAUD_CNT.
- valid/data update on the clock edge following the stop sample. Latency from detection to valid = BAUD_CNT/2 + 9*BAUD_CNT + 1 cycles.
- Holding register rules:
  - valid&&ready: valid clears next cycle.
  - Completion with valid=0: load data, set valid=1.
  - Completion with valid=1 and ready=1 in the same cycle: load the new byte, valid stays 1, no overrun.
  - Completion with valid=1 and ready=0: keep the old data, drop the new byte, pulse overrun for 1 cycle.
- data never changes while valid=1 && ready=0.
- Reset mid-frame: immediate return to IDLE. The partial byte is lost and no flags are raised.
- The receiver ignores rx in every state except the defined sample points and the IDLE edge check.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each sample point takes the 2-of-3 majority of rx_s at cycles (point-1, point, point+1). The start-bit validation uses the same vote. A single-cycle glitch at a sample point is rejected. Latency is unchanged because the value is registered from the three-tap shift.
- Undefined: the single rx_s value at the sample point is used.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP};
  - DATA_BITS=8;
  - default BAUD_CNT constant, shared with uart_tx.
- Sub-module uart_rx_filter: 2-flop synchroniser, edge history and optional majority vote. It outputs rx_s, the detection (falling-edge) strobe and the sample value.
- FSM, counters and holding register stay in uart_rx.

Test Plan:
- BAUD_CNT=10, ready=1; send 8'hB9 frame (start, 1,0,0,1,1,1,0,1, stop) -> valid pulses 1 cycle at detection+96, data=8'hB9, no flags.
- ready=0; send 8'h3C then 8'hA5 back-to-back -> data stays 8'h3C, valid held, overrun pulses once at the second stop sample. Raise ready -> valid drops next cycle.
- Send 8'h55 with stop bit 0 -> frame_err 1-cycle pulse, valid stays 0. Hold rx low 30 bit periods, then idle -> no further activity. Next frame 8'h81 is received correctly.
- 3-cycle low glitch on idle line -> start sample reads 1, FSM returns to IDLE, no valid or flags.
- Assert rst during data bit 4 of 8'hFF, release, send 8'h12 -> only 8'h12 is delivered. All outputs are 0 during reset.
- With UART_RX_MAJORITY_EN: 1-cycle high glitch exactly at a data-bit-2 sample point while sending 8'h00 -> data=8'h00. Without the macro the same stimulus gives 8'h04.
